// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write bypass, optional hardwired
// zero register and a clear sequencer that zeroes the array after reset or on request.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_IDX = 2**ADDR_W-1
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Clear,
  input  logic [NUM_RD*ADDR_W-1:0]   RA,
  output logic [NUM_RD*DATA_W-1:0]   BusR,
  input  logic [ADDR_W-1:0]          RW,
  input  logic [DATA_W-1:0]          BusW,
  input  logic                       RegWr,
  output logic                       Ready,
  output logic                       WrIgnored
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH-1);
  localparam bit                ZeroOn   = (ZERO_EN != 0);

  typedef enum logic {StClear, StIdle} state_t;

  state_t            stateQ, stateD;
  logic [ADDR_W-1:0] cnt, cntD;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              zeroWr;

  assign zeroWr = ZeroOn && (RW == ZeroAddr);

  always_comb begin
    stateD = stateQ;
    cntD   = cnt;
    case (stateQ)
      StClear: begin
        cntD = cnt + 1'b1;
        if (cnt == LastAddr) stateD = StIdle;
      end
      StIdle: begin
        if (Clear) begin
          stateD = StClear;
          cntD   = '0;
        end
      end
      default: begin
        stateD = StClear;
        cntD   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stateQ    <= StClear;
      cnt       <= '0;
      Ready     <= 1'b0;
      WrIgnored <= 1'b0;
    end else begin
      stateQ    <= stateD;
      cnt       <= cntD;
      Ready     <= (stateD == StIdle);
      WrIgnored <= (stateQ == StClear) && RegWr;
    end
  end

  // The array has no reset; the clear walk is the only thing that zeroes it.
  always_ff @(posedge Clk) begin
    if (stateQ == StClear) begin
      mem[cnt] <= '0;
    end else if (RegWr && !zeroWr) begin
      mem[RW] <= BusW;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdData;

    assign addr = RA[i*ADDR_W +: ADDR_W];

    always_comb begin
      rdData = mem[addr];
      if (!Ready) begin
        rdData = '0;
      end else if (ZeroOn && (addr == ZeroAddr)) begin
        rdData = '0;
      end else if (RegWr && (RW == addr)) begin
        rdData = BusW;
      end
    end

    assign BusR[i*DATA_W +: DATA_W] = rdData;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 64x32 two-port build plus a small
// 32-bit, 8-entry, four-port build without a zero register.
module tb_regfile_mp;

  logic         Clk;
  logic         Rst_n, Clear, RegWr;
  logic [9:0]   RA;
  logic [127:0] BusR;
  logic [4:0]   RW;
  logic [63:0]  BusW;
  logic         Ready, WrIgnored;

  logic         Rst2_n, Clear2, RegWr2;
  logic [11:0]  RA2;
  logic [127:0] BusR2;
  logic [2:0]   RW2;
  logic [31:0]  BusW2;
  logic         Ready2, WrIgnored2;

  int passCnt = 0;
  int failCnt = 0;
  int total   = 0;
  int n;

  localparam logic [63:0] Dead = 64'hDEAD_BEEF_0000_0001;

  regfile_mp dut (
    .Clk(Clk), .Rst_n(Rst_n), .Clear(Clear), .RA(RA), .BusR(BusR),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .Ready(Ready), .WrIgnored(WrIgnored)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4), .ZERO_EN(0)) dut2 (
    .Clk(Clk), .Rst_n(Rst2_n), .Clear(Clear2), .RA(RA2), .BusR(BusR2),
    .RW(RW2), .BusW(BusW2), .RegWr(RegWr2), .Ready(Ready2), .WrIgnored(WrIgnored2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    Rst_n = 1'b0; Clear = 1'b0; RegWr = 1'b0; RA = '0; RW = '0; BusW = '0;
    Rst2_n = 1'b0; Clear2 = 1'b0; RegWr2 = 1'b0; RA2 = '0; RW2 = '0; BusW2 = '0;
    #1;
    check("rstReady", 128'(Ready), 128'(0));
    check("rstWrIgn", 128'(WrIgnored), 128'(0));
    check("rstBusR", BusR, 128'(0));

    // Reset for three cycles, then the 32-cycle clear
    repeat (3) step();
    Rst_n = 1'b1;
    n = 0;
    while (!Ready && n < 200) begin step(); n++; end
    check("clrCycles", 128'(n), 128'(32));
    for (int a = 0; a < 32; a++) begin
      RA = {2{5'(a)}};
      #1;
      check("clrRead", BusR, 128'(0));
    end

    // Write with same-cycle bypass on both ports, then from the array
    RW = 5'd5; BusW = Dead; RegWr = 1'b1; RA = {5'd5, 5'd5};
    #1;
    check("bypass", BusR, {Dead, Dead});
    step();
    RegWr = 1'b0;
    #1;
    check("stored", BusR, {Dead, Dead});
    RA = {5'd6, 5'd5};
    #1;
    check("indep", BusR, {64'h0, Dead});

    // Zero register: write to 31 is discarded, entry 30 keeps its value
    RW = 5'd30; BusW = 64'h3030; RegWr = 1'b1;
    step();
    RW = 5'd31; BusW = '1; RegWr = 1'b1; RA = {5'd30, 5'd31};
    #1;
    check("zeroBypass", BusR, {64'h3030, 64'h0});
    step();
    RegWr = 1'b0;
    check("zeroWrIgn", 128'(WrIgnored), 128'(0));
    #1;
    check("zeroStored", BusR, {64'h3030, 64'h0});

    // Write during clear is dropped; Clear held in CLEAR must not restart the walk
    Clear = 1'b1;
    step();
    check("clrReqReady", 128'(Ready), 128'(0));
    RegWr = 1'b1; RW = 5'd3; BusW = 64'd7; RA = {5'd5, 5'd3};
    #1;
    check("clrBusR", BusR, 128'(0));
    step();
    Clear = 1'b0; RegWr = 1'b0;
    check("wrIgnHi", 128'(WrIgnored), 128'(1));
    step();
    check("wrIgnLo", 128'(WrIgnored), 128'(0));
    n = 2;
    while (!Ready && n < 200) begin step(); n++; end
    check("clrReqCycles", 128'(n), 128'(32));
    #1;
    check("clrDropped", BusR, 128'(0));

    // Reset ten cycles into a clear restarts the full walk
    RW = 5'd12; BusW = 64'hC; RegWr = 1'b1;
    step();
    RegWr = 1'b0; RA = {5'd12, 5'd12};
    #1;
    check("preRst", BusR, {64'hC, 64'hC});
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    repeat (10) step();
    Rst_n = 1'b0;
    #1;
    check("midRstReady", 128'(Ready), 128'(0));
    check("midRstBusR", BusR, 128'(0));
    step();
    step();
    Rst_n = 1'b1;
    n = 0;
    while (!Ready && n < 200) begin step(); n++; end
    check("midRstCycles", 128'(n), 128'(32));
    for (int a = 0; a < 32; a++) begin
      RA = {2{5'(a)}};
      #1;
      check("midRstRead", BusR, 128'(0));
    end

    // Small build: 8-entry clear, no zero register, four ports
    Rst2_n = 1'b1;
    n = 0;
    while (!Ready2 && n < 200) begin step(); n++; end
    check("p2Cycles", 128'(n), 128'(8));
    RW2 = 3'd7; BusW2 = 32'hA5; RegWr2 = 1'b1; RA2 = {4{3'd7}};
    #1;
    check("p2Bypass", BusR2, {4{32'hA5}});
    step();
    RegWr2 = 1'b0;
    #1;
    check("p2Stored", BusR2, {4{32'hA5}});
    RA2 = {3'd7, 3'd6, 3'd7, 3'd7};
    #1;
    check("p2Indep", BusR2, {32'hA5, 32'h0, 32'hA5, 32'hA5});

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the single-cycle datapath. It replaces the fixed 32×64, 2-read-port file. It adds:
- a configurable number of read ports;
- same-cycle write-to-read bypass;
- an optional hardwired zero register;
- a clear sequencer that zeroes every entry after reset, or on request, while signalling not-ready.

It sits between decode and the ALU, fed by the writeback mux.

## Interface
- DATA_W, 64, data width in bits
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_EN, 1, when 1 the entry ZERO_IDX always reads 0 and ignores writes
- ZERO_IDX, 2**ADDR_W-1, index of the zero register (XZR = 31 by default)

- Clk  input  1  clock, all state updates on rising edge
- Rst_n  input  1  asynchronous active-low reset
- Clear  input  1  synchronous request to re-run the clear sequence
- RA  input  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- BusR  output  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- RW  input  ADDR_W  write address
- BusW  input  DATA_W  write data
- RegWr  input  1  write enable
- Ready  output  1  high when the file accepts writes and returns stored data
- WrIgnored  output  1  registered one-cycle pulse: a write was dropped because Ready was low

## Operation
- Storage: DEPTH × DATA_W array, written only on the rising edge of Clk. No reset on the array itself; zeroing is done by the sequencer.
- FSM states:
  - CLEAR: an ADDR_W-bit counter Cnt walks 0..DEPTH-1 and writes 0 to entry Cnt each cycle. After writing DEPTH-1 the FSM goes to IDLE.
  - IDLE: normal operation. Clear=1 in IDLE goes to CLEAR with Cnt=0. Clear=1 in CLEAR is ignored and does not restart the walk.
- Write (IDLE only): on a rising edge with RegWr=1, entry RW ← BusW. Exception: if ZERO_EN=1 and RW=ZERO_IDX, the write is discarded silently with no WrIgnored pulse.
- Write in CLEAR: RegWr=1 is dropped, and WrIgnored=1 on the following cycle. This applies even for RW=ZERO_IDX.
- Read port i, combinational, priority order:
  1. Ready=0 → 0;
  2. ZERO_EN=1 and RA[i]=ZERO_IDX → 0;
  3. RegWr=1 and RW=RA[i] → BusW (bypass);
  4. otherwise the stored entry RA[i].
- All read ports are fully independent. Any number of ports may address the same entry.
- Ready is a registered output, equal to (state==IDLE).

## Timing
- Reset (Rst_n=0, asynchronous): state=CLEAR, Cnt=0, Ready=0, WrIgnored=0. BusR=0 follows from Ready=0. Array contents are undefined until the clear completes.
- Reset asserted mid-clear or mid-operation: returns immediately to the reset state above, and a full DEPTH-cycle clear restarts after release.
- Clear latency: DEPTH rising edges after Rst_n deasserts. Ready rises after the edge that writes entry DEPTH-1 (32 cycles at ADDR_W=5).
- Clear request: Clear=1 sampled at edge k drops Ready after edge k. Ready returns high DEPTH edges later.
- Write latency: the data is visible through the bypass in the same cycle, and from the array from the next cycle on.
- Simultaneous Clear=1 and RegWr=1 in IDLE: the write commits at that edge, then the clear starts, so the entry is zeroed later.
- WrIgnored: asserted for exactly one cycle per dropped write. Back-to-back drops keep it high.
- Cnt wraps naturally from DEPTH-1 to 0 at the transition to IDLE, with no overflow flag.

## Test plan
- Reset then idle: hold Rst_n=0 for 3 cycles and release. Required: Ready=0 for 32 cycles, then 1. All ports read 0 for every address 0..31.
- Write/read with bypass: in IDLE set RW=5, BusW=64'hDEAD_BEEF_0000_0001, RegWr=1, RA0=5, RA1=5. Required: both BusR ports = DEAD_BEEF_0000_0001 in the same cycle, and the value holds after RegWr drops.
- Zero register: write 64'hFFFF… to RW=31, then read RA0=31. Required: BusR0=0, WrIgnored stays 0, and entry 30 is untouched.
- Write during clear: pulse Clear, then RegWr=1 with RW=3, BusW=7 on the next cycle. Required: WrIgnored=1 for one cycle. After Ready returns, RA0=3 reads 0.
- Reset mid-clear: assert Rst_n=0 at cycle 10 of a clear, release after 2 cycles. Required: Ready=0 for a full 32 cycles after release, then all entries read 0.
- Parameter sweep: DATA_W=32, ADDR_W=3, NUM_RD=4, ZERO_EN=0. Required: Ready after 8 cycles. Writing 0xA5 to entry 7 reads 0xA5 on all four ports.
